// File: rtl/match_scorer.sv
// match_scorer: match-level referee for the two-player tug-of-war game.
// It detects round wins at the playfield ends, keeps a score per player,
// drives two active-low 7-segment digits (bit0=a .. bit6=g), pulses
// round_restart between rounds and latches the match winner.
// Optional macro ROUND_GAP_EN: when it is defined, RESTART is held for
// GAP_CYCLES cycles by an 8-bit down-counter. When it is undefined,
// RESTART lasts one cycle.
module match_scorer #(
    parameter int WIN_ROUNDS = 3,
    parameter int GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       led_left_end,
    input  logic       led_right_end,
    output logic       round_restart,
    output logic [6:0] hex_left,
    output logic [6:0] hex_right,
    output logic       match_over,
    output logic [1:0] match_winner
);

    localparam logic [1:0] S_PLAY    = 2'd0;
    localparam logic [1:0] S_RESTART = 2'd1;
    localparam logic [1:0] S_OVER    = 2'd2;

    localparam logic [3:0] WIN_SCORE = 4'(WIN_ROUNDS);

    // Reject out-of-range parameters at elaboration rather than build a broken referee
    if (WIN_ROUNDS < 1 || WIN_ROUNDS > 9) begin : g_bad_win
        $error("match_scorer: WIN_ROUNDS must be 1..9");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("match_scorer: GAP_CYCLES must be 1..255");
    end

    logic [1:0] state, state_n;
    logic [3:0] score_l, score_l_n;
    logic [3:0] score_r, score_r_n;
    logic [1:0] winner_n;
    logic       left_win, right_win;

`ifdef ROUND_GAP_EN
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);
    logic [7:0] gap_cnt, gap_cnt_n;
`endif

    // Active-low segment patterns for the digits 0..9 (bit6=g .. bit0=a)
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // A simultaneous press by both players never scores, so the two terms cannot both be true
    assign left_win  = led_left_end  & L & ~R;
    assign right_win = led_right_end & R & ~L;

    // Next-state, score and winner logic; a win is only accepted in PLAY
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_n   = state;
        score_l_n = score_l;
        score_r_n = score_r;
        winner_n  = match_winner;
`ifdef ROUND_GAP_EN
        gap_cnt_n = gap_cnt;
`endif
        case (state)
            S_PLAY: begin
                if (left_win) begin
                    score_l_n = score_l + 4'd1;
                    if (score_l_n == WIN_SCORE) begin
                        state_n  = S_OVER;
                        winner_n = 2'b01;
                    end else begin
                        state_n = S_RESTART;
`ifdef ROUND_GAP_EN
                        gap_cnt_n = GAP_LOAD;
`endif
                    end
                end else if (right_win) begin
                    score_r_n = score_r + 4'd1;
                    if (score_r_n == WIN_SCORE) begin
                        state_n  = S_OVER;
                        winner_n = 2'b10;
                    end else begin
                        state_n = S_RESTART;
`ifdef ROUND_GAP_EN
                        gap_cnt_n = GAP_LOAD;
`endif
                    end
                end
            end
            S_RESTART: begin
`ifdef ROUND_GAP_EN
                if (gap_cnt == 8'd0) begin
                    state_n = S_PLAY;
                end else begin
                    gap_cnt_n = gap_cnt - 8'd1;
                end
`else
                state_n = S_PLAY;
`endif
            end
            S_OVER:  state_n = S_OVER;
            default: state_n = S_PLAY;
        endcase
    end

    // State, scores and all outputs register together, so every output is glitch-free and Moore
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_PLAY;
            score_l       <= 4'd0;
            score_r       <= 4'd0;
            round_restart <= 1'b0;
            match_over    <= 1'b0;
            match_winner  <= 2'b00;
            hex_left      <= 7'b1000000;
            hex_right     <= 7'b1000000;
`ifdef ROUND_GAP_EN
            gap_cnt       <= 8'd0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state         <= state_n;
            score_l       <= score_l_n;
            score_r       <= score_r_n;
            round_restart <= (state_n == S_RESTART);
            match_over    <= (state_n == S_OVER);
            match_winner  <= winner_n;
            hex_left      <= seg7(score_l_n);
            hex_right     <= seg7(score_r_n);
`ifdef ROUND_GAP_EN
            gap_cnt       <= gap_cnt_n;
`endif
        end
    end

endmodule
